conv_line_scheduler: RTL and testbench

Sequences a raster pixel stream into the 3x3 convolution datapath. Three rotating line buffers hold the two previous lines. Each accepted pixel therefore leaves the block as a vertically aligned 3-pixel column (lines y-2, y-1, y). A small frame state machine suppresses or edge-fills output until enough lines are buffered. The block sits between the camera/frame-buffer pixel stream and the convolution instance.

---
 rtl/conv_line_scheduler.sv | 139 +++++++++++++
 tb/tb_conv_line_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_scheduler.sv
// Raster-to-column scheduler for the 3x3 convolution: three rotating line buffers emit y-2/y-1/y columns.
// Optional build macro CONV_EDGE_REPLICATE_EN: emit edge-replicated columns while the first two lines fill.
//
// state | meaning
// IDLE  | waiting for frame start (pixel 0,0); all other pixels ignored
// FILL0 | line 0 of the frame being written
// FILL1 | line 1 of the frame being written
// RUN   | two previous lines buffered; every accepted pixel yields a full column
module conv_line_scheduler #(
    parameter int HRES = 320,
    parameter int VRES = 240
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [15:0]       pixel_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              data_valid_in,
    output logic [2:0][15:0]  data_out,
    output logic [10:0]       hcount_out,
    output logic [9:0]        vcount_out,
    output logic              data_valid_out,
    output logic              busy_out
);

    localparam int          AW     = (HRES > 1) ? $clog2(HRES) : 1;
    localparam logic [10:0] H_LAST = 11'(HRES - 1);
    localparam logic [9:0]  V_LAST = 10'(VRES - 1);

    typedef enum logic [1:0] {IDLE, FILL0, FILL1, RUN} state_t;

    state_t        state, state_eff, state_nxt;
    logic [1:0]    wp, wp_eff, wp_nxt;
    logic          accepted, frame_start, eol, wr_en, col_valid;
    logic [AW-1:0] addr;

    logic [15:0]   line_mem [3][HRES];
    logic [15:0]   rd [3];
    logic [15:0]   rd_top, rd_mid;

    logic          s1_valid;
    logic [15:0]   s1_pixel;
    logic [10:0]   s1_h;
    logic [9:0]    s1_v;
    logic [1:0]    s1_wp;
`ifdef CONV_EDGE_REPLICATE_EN
    state_t        s1_mode;
`endif

    // Frame start overrides both state and write pointer for the pixel that carries it.
    always_comb begin
        accepted    = data_valid_in && (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
        frame_start = accepted && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        eol         = accepted && (hcount_in == H_LAST);
        state_eff   = frame_start ? FILL0 : state;
        wp_eff      = frame_start ? 2'd0 : wp;
        wr_en       = accepted && (state_eff != IDLE);
        addr        = hcount_in[AW-1:0];
        state_nxt   = state_eff;
        wp_nxt      = wp_eff;
        if (wr_en && eol && !frame_start) begin
            wp_nxt = (wp_eff == 2'd2) ? 2'd0 : wp_eff + 2'd1;
            case (state_eff)
                FILL0:   state_nxt = FILL1;
                FILL1:   state_nxt = RUN;
                RUN:     state_nxt = (vcount_in == V_LAST) ? IDLE : RUN;
                default: state_nxt = state_eff;
            endcase
        end
`ifdef CONV_EDGE_REPLICATE_EN
        col_valid = wr_en;
`else
        col_valid = wr_en && (state_eff == RUN);
`endif
    end

    // Buffer wp is never in the read set, so read-during-write ordering is irrelevant.
    always_ff @(posedge clk_in) begin
        if (wr_en)
            line_mem[wp_eff][addr] <= pixel_in;
        for (int i = 0; i < 3; i++)
            rd[i] <= line_mem[i][addr];
    end

    always_comb begin
        case (s1_wp)
            2'd0:    begin rd_top = rd[1]; rd_mid = rd[2]; end
            2'd1:    begin rd_top = rd[2]; rd_mid = rd[0]; end
            default: begin rd_top = rd[0]; rd_mid = rd[1]; end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            wp             <= 2'd0;
            busy_out       <= 1'b0;
            s1_valid       <= 1'b0;
            s1_pixel       <= '0;
            s1_h           <= '0;
            s1_v           <= '0;
            s1_wp          <= 2'd0;
`ifdef CONV_EDGE_REPLICATE_EN
            s1_mode        <= IDLE;
`endif
            data_out       <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            data_valid_out <= 1'b0;
        end else begin
            state          <= state_nxt;
            wp             <= wp_nxt;
            busy_out       <= (state_nxt != IDLE);
            s1_valid       <= col_valid;
            s1_pixel       <= pixel_in;
            s1_h           <= hcount_in;
            s1_v           <= vcount_in;
            s1_wp          <= wp_eff;
`ifdef CONV_EDGE_REPLICATE_EN
            s1_mode        <= state_eff;
`endif
            data_valid_out <= s1_valid;
            hcount_out     <= s1_h;
            vcount_out     <= s1_v;
            data_out[2]    <= s1_pixel;
`ifdef CONV_EDGE_REPLICATE_EN
            case (s1_mode)
                FILL0:   begin data_out[1] <= s1_pixel; data_out[0] <= s1_pixel; end
                FILL1:   begin data_out[1] <= rd_mid;   data_out[0] <= rd_mid;   end
                default: begin data_out[1] <= rd_mid;   data_out[0] <= rd_top;   end
            endcase
`else
            data_out[1]    <= rd_mid;
            data_out[0]    <= rd_top;
`endif
        end
    end

endmodule

// File: tb/tb_conv_line_scheduler.sv
// Scoreboard bench for conv_line_scheduler at HRES=8, VRES=4 with pixel = v*16+h.
// Build with or without CONV_EDGE_REPLICATE_EN; expectations follow the same macro.
module tb_conv_line_scheduler;

    localparam int HR = 8;
    localparam int VR = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [15:0]       pixel_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              data_valid_in;
    logic [2:0][15:0]  data_out;
    logic [10:0]       hcount_out;
    logic [9:0]        vcount_out;
    logic              data_valid_out;
    logic              busy_out;

    typedef struct {
        logic [47:0] d;
        int          h;
        int          v;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   valid_cnt = 0;

    conv_line_scheduler #(.HRES(HR), .VRES(VR)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .pixel_in      (pixel_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .data_valid_in (data_valid_in),
        .data_out      (data_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .data_valid_out(data_valid_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Monitor: every valid column must match the oldest expected entry.
    always @(negedge clk_in) begin
        if (!rst_in && data_valid_out) begin
            valid_cnt++;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_column: got data=%012h h=%0d v=%0d, required no valid output",
                         data_out, hcount_out, vcount_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_out !== e.d || hcount_out !== 11'(e.h) || vcount_out !== 10'(e.v)) begin
                    fails++;
                    $display("FAIL column: got data=%012h h=%0d v=%0d, required data=%012h h=%0d v=%0d",
                             data_out, hcount_out, vcount_out, e.d, e.h, e.v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // role: -1 no output, 0 = frame line 0, 1 = frame line 1, 2 = full column
    task automatic pix(input int h, input int v, input int role);
        logic [15:0] p;
        exp_t        e;
        p   = 16'(v * 16 + h);
        e.h = h;
        e.v = v;
        if (role == 2) begin
            e.d = {p, 16'(p - 16), 16'(p - 32)};
            q.push_back(e);
        end
`ifdef CONV_EDGE_REPLICATE_EN
        if (role == 0) begin
            e.d = {p, p, p};
            q.push_back(e);
        end
        if (role == 1) begin
            e.d = {p, 16'(p - 16), 16'(p - 16)};
            q.push_back(e);
        end
`endif
        data_valid_in = 1'b1;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        pixel_in      = p;
        @(posedge clk_in);
        #1;
    endtask

    task automatic line(input int v, input int role);
        for (int h = 0; h < HR; h++) pix(h, v, role);
    endtask

    task automatic idle(input int n);
        data_valid_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        rst_in        = 1'b1;
        pixel_in      = '0;
        hcount_in     = '0;
        vcount_in     = '0;
        data_valid_in = 1'b0;
        #2;
        chk("reset_data_out", data_out, 48'h0);
        chk("reset_hcount_out", 48'(hcount_out), 48'h0);
        chk("reset_vcount_out", 48'(vcount_out), 48'h0);
        chk("reset_data_valid_out", 48'(data_valid_out), 48'h0);
        chk("reset_busy_out", 48'(busy_out), 48'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // Frame 1: normal frame with blanking inserted mid line 2.
        valid_cnt = 0;
        line(0, 0);
        line(1, 1);
        idle(3);
`ifdef CONV_EDGE_REPLICATE_EN
        chk("fill_lines_valid_cnt", 48'(valid_cnt), 48'd16);
`else
        chk("fill_lines_valid_cnt", 48'(valid_cnt), 48'd0);
`endif
        for (int h = 0; h < 4; h++) pix(h, 2, 2);
        pix(8, 2, -1);
        pix(0, 4, -1);
        pix(5, 4, -1);
        for (int h = 4; h < HR; h++) pix(h, 2, 2);
        for (int h = 0; h < HR - 1; h++) pix(h, 3, 2);
        chk("busy_before_last_pixel", 48'(busy_out), 48'h1);
        pix(HR - 1, 3, 2);
        chk("busy_after_last_pixel", 48'(busy_out), 48'h0);
        idle(3);
`ifdef CONV_EDGE_REPLICATE_EN
        chk("frame1_valid_cnt", 48'(valid_cnt), 48'd32);
`else
        chk("frame1_valid_cnt", 48'(valid_cnt), 48'd16);
`endif
        chk("frame1_queue_drained", 48'(q.size()), 48'd0);

        // Frame 2: frame start arrives during line 2.
        valid_cnt = 0;
        line(0, 0);
        line(1, 1);
        for (int h = 0; h < 5; h++) pix(h, 2, 2);
        line(0, 0);
        chk("restart_busy", 48'(busy_out), 48'h1);
        line(1, 1);
        line(2, 2);
        line(3, 2);
        idle(3);
`ifdef CONV_EDGE_REPLICATE_EN
        chk("frame2_valid_cnt", 48'(valid_cnt), 48'd53);
`else
        chk("frame2_valid_cnt", 48'(valid_cnt), 48'd21);
`endif
        chk("frame2_queue_drained", 48'(q.size()), 48'd0);

        // Frame 3: asynchronous reset mid line 2.
        line(0, 0);
        line(1, 1);
        for (int h = 0; h < 5; h++) pix(h, 2, 2);
        data_valid_in = 1'b0;
        chk("pre_reset_valid", 48'(data_valid_out), 48'h1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("async_rst_valid", 48'(data_valid_out), 48'h0);
        chk("async_rst_data", data_out, 48'h0);
        chk("async_rst_hcount", 48'(hcount_out), 48'h0);
        chk("async_rst_busy", 48'(busy_out), 48'h0);
        q.delete();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        valid_cnt = 0;
        for (int h = 5; h < HR; h++) pix(h, 2, -1);
        line(3, -1);
        idle(3);
        chk("post_reset_ignored_busy", 48'(busy_out), 48'h0);
        chk("post_reset_ignored_cnt", 48'(valid_cnt), 48'd0);
        line(0, 0);
        line(1, 1);
        line(2, 2);
        line(3, 2);
        idle(3);
`ifdef CONV_EDGE_REPLICATE_EN
        chk("frame4_valid_cnt", 48'(valid_cnt), 48'd32);
`else
        chk("frame4_valid_cnt", 48'(valid_cnt), 48'd16);
`endif
        chk("frame4_queue_drained", 48'(q.size()), 48'd0);
        chk("frame4_idle", 48'(busy_out), 48'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
